game_round_ctrl: RTL and testbench

GAME_ROUND_CTRL -- requirements
Module: game_round_ctrl

---
 rtl/game_round_ctrl.sv | 150 +++++++++++++++
 tb/tb_game_round_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/game_round_ctrl.sv
// Round sequencer for a reaction game: seed the randomizer, show the target, open a
// play window, score the round. Optional build macro GAME_STREAK_EN adds a hit-streak bonus.
module game_round_ctrl #(
  parameter int ROUNDS        = 8,
  parameter int SHOW_CYCLES   = 16,
  parameter int WINDOW_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [8:0] token,
  input  logic       hit,
  input  logic       rnd_valid,
  input  logic [7:0] rnd_data,
  output logic       rnd_req,
  output logic [8:0] seed,
  output logic [7:0] light,
  output logic       hm_enable,
  output logic [7:0] score,
  output logic [7:0] round_cnt,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    IDLE,
    SEED,
    WAIT_RND,
    SHOW,
    PLAY,
    SCORE,
    DONE
  } state_t;

  localparam int SW = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;
  localparam int WW = $clog2(WINDOW_CYCLES + 1);
  localparam logic [SW-1:0] SHOW_LAST = SW'(SHOW_CYCLES - 1);
  localparam logic [WW-1:0] WIN_LAST  = WW'(WINDOW_CYCLES);

  state_t        state;
  state_t        next_state;
  logic [SW-1:0] show_cnt;
  logic [WW-1:0] win_cnt;
  logic          hit_q;
  logic [8:0]    score_sum;
  logic [7:0]    score_next;
  logic          last_round;

`ifdef GAME_STREAK_EN
  // Consecutive hits modulo 4; a hit arriving with the count at 3 is a 4th, 8th, ... hit.
  logic [1:0] streak;
`endif

  always_comb begin
    next_state = state;
    last_round = (({1'b0, round_cnt} + 9'd1) == 9'(ROUNDS));
    case (state)
      IDLE:     if (start) next_state = SEED;
      SEED:     next_state = WAIT_RND;
      WAIT_RND: if (rnd_valid) next_state = SHOW;
      SHOW:     if (show_cnt == SHOW_LAST) next_state = PLAY;
      PLAY:     if (hit || (win_cnt == WIN_LAST)) next_state = SCORE;
      SCORE:    next_state = last_round ? DONE : SEED;
      DONE:     if (start) next_state = SEED;
      default:  next_state = IDLE;
    endcase
  end

  always_comb begin
    score_sum = {1'b0, score};
`ifdef GAME_STREAK_EN
    if (hit_q) score_sum = {1'b0, score} + ((streak == 2'd3) ? 9'd2 : 9'd1);
`else
    if (hit_q) score_sum = {1'b0, score} + 9'd1;
`endif
    score_next = score_sum[8] ? 8'hFF : score_sum[7:0];
  end

  // Outputs are registered from next_state so each one is valid in the state it belongs to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rnd_req   <= 1'b0;
      seed      <= '0;
      light     <= '0;
      hm_enable <= 1'b0;
      score     <= '0;
      round_cnt <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      show_cnt  <= '0;
      win_cnt   <= '0;
      hit_q     <= 1'b0;
`ifdef GAME_STREAK_EN
      streak    <= '0;
`endif
    end else begin
      state     <= next_state;
      rnd_req   <= (next_state == SEED);
      seed      <= (next_state == SEED) ? token : 9'd0;
      hm_enable <= (next_state == SHOW);
      busy      <= (next_state == SEED) || (next_state == WAIT_RND) || (next_state == SHOW) ||
                   (next_state == PLAY) || (next_state == SCORE);
      done      <= (next_state == DONE);
      if (next_state == DONE) light <= '0;

      case (state)
        IDLE, DONE: begin
          if (start) begin
            score     <= '0;
            round_cnt <= '0;
`ifdef GAME_STREAK_EN
            streak    <= '0;
`endif
          end
        end
        WAIT_RND: begin
          if (rnd_valid) light <= (rnd_data == 8'h00) ? 8'h01 : rnd_data;
        end
        SHOW: begin
          if (show_cnt == SHOW_LAST) begin
            show_cnt <= '0;
            win_cnt  <= WW'(1);
          end else begin
            show_cnt <= show_cnt + 1'b1;
          end
        end
        PLAY: begin
          // A hit on the final window cycle still counts as a hit.
          if (next_state == SCORE) begin
            hit_q   <= hit;
            win_cnt <= '0;
          end else begin
            win_cnt <= win_cnt + 1'b1;
          end
        end
        SCORE: begin
          score     <= score_next;
          round_cnt <= round_cnt + 8'd1;
          hit_q     <= 1'b0;
`ifdef GAME_STREAK_EN
          streak    <= hit_q ? (streak + 2'd1) : 2'd0;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_game_round_ctrl.sv
// Randomized bench for game_round_ctrl: rounds driven at the transaction level and
// checked against an arithmetic score/round model.
module tb_game_round_ctrl;
  localparam int ROUNDS        = 8;
  localparam int SHOW_CYCLES   = 16;
  localparam int WINDOW_CYCLES = 1024;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [8:0] token = '0;
  logic       hit = 1'b0;
  logic       rnd_valid = 1'b0;
  logic [7:0] rnd_data = '0;
  logic       rnd_req;
  logic [8:0] seed;
  logic [7:0] light;
  logic       hm_enable;
  logic [7:0] score;
  logic [7:0] round_cnt;
  logic       busy;
  logic       done;

  int errors = 0;
  int checks = 0;
  int model_score = 0;
  int model_rounds = 0;
  int model_streak = 0;
  logic [8:0] cur_token = '0;

  game_round_ctrl #(
    .ROUNDS(ROUNDS),
    .SHOW_CYCLES(SHOW_CYCLES),
    .WINDOW_CYCLES(WINDOW_CYCLES)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .token(token), .hit(hit),
    .rnd_valid(rnd_valid), .rnd_data(rnd_data), .rnd_req(rnd_req), .seed(seed),
    .light(light), .hm_enable(hm_enable), .score(score), .round_cnt(round_cnt),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Score rules: +1 per hit, +2 on every 4th consecutive hit when streaks are enabled, cap 255.
  task automatic model_round(input bit was_hit);
    model_rounds++;
    if (was_hit) begin
      model_streak++;
`ifdef GAME_STREAK_EN
      model_score += ((model_streak % 4) == 0) ? 2 : 1;
`else
      model_score += 1;
`endif
      if (model_score > 255) model_score = 255;
    end else begin
      model_streak = 0;
    end
  endtask

  task automatic start_game();
    @(negedge clk);
    start = 1'b1;
    token = 9'($urandom);
    cur_token = token;
    @(negedge clk);
    start = 1'b0;
    model_score = 0;
    model_rounds = 0;
    model_streak = 0;
    checkOutput("start_busy", 32'(busy), 32'd1);
    checkOutput("start_done", 32'(done), 32'd0);
    checkOutput("start_score_clr", 32'(score), 32'd0);
    checkOutput("start_round_clr", 32'(round_cnt), 32'd0);
  endtask

  // One round, entered at the negedge where rnd_req should be high.
  // hit_at: PLAY cycle (1..WINDOW_CYCLES) carrying hit, 0 for a miss.
  task automatic applyStimulus(input logic [7:0] data, input int delay, input int hit_at,
                               input bit start_in_play, input bit abort_in_show);
    logic [7:0] exp_light;
    int show_count;
    int kend;
    exp_light = (data == 8'h00) ? 8'h01 : data;
    checkOutput("rnd_req_pulse", 32'(rnd_req), 32'd1);
    checkOutput("seed", 32'(seed), 32'(cur_token));
    for (int j = 1; j <= delay; j++) begin
      @(negedge clk);
      if (j == 1) checkOutput("rnd_req_end", 32'(rnd_req), 32'd0);
      hit = 1'($urandom);
      if (j == delay) begin
        rnd_valid = 1'b1;
        rnd_data = data;
      end
    end
    show_count = 0;
    for (int i = 1; i <= SHOW_CYCLES; i++) begin
      @(negedge clk);
      if (i == 1) begin
        rnd_valid = 1'b0;
        rnd_data = 8'($urandom);
        checkOutput("light", 32'(light), 32'(exp_light));
      end
      if (abort_in_show && i == 3) begin
        #3 rst_n = 1'b0;
        #1;
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_hm_enable", 32'(hm_enable), 32'd0);
        checkOutput("abort_light", 32'(light), 32'd0);
        checkOutput("abort_score", 32'(score), 32'd0);
        checkOutput("abort_round_cnt", 32'(round_cnt), 32'd0);
        checkOutput("abort_req_done", 32'({rnd_req, done}), 32'd0);
        checkOutput("abort_seed", 32'(seed), 32'd0);
        hit = 1'b0;
        model_score = 0;
        model_rounds = 0;
        model_streak = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      show_count += int'(hm_enable);
      hit = 1'($urandom);
    end
    checkOutput("show_len", 32'(show_count), 32'(SHOW_CYCLES));
    kend = (hit_at == 0) ? WINDOW_CYCLES : hit_at;
    for (int k = 1; k <= kend; k++) begin
      @(negedge clk);
      if (k == 1) checkOutput("play_hm_off", 32'(hm_enable), 32'd0);
      hit = (k == hit_at);
      start = start_in_play && (k == 3);
    end
    @(negedge clk);
    hit = 1'b0;
    start = 1'b0;
    checkOutput("score_state_busy", 32'(busy), 32'd1);
    checkOutput("score_hold", 32'(score), 32'(model_score));
    token = 9'($urandom);
    cur_token = token;
    model_round(hit_at != 0);
    @(negedge clk);
    checkOutput("score", 32'(score), 32'(model_score));
    checkOutput("round_cnt", 32'(round_cnt), 32'(model_rounds));
    if (model_rounds == ROUNDS) begin
      checkOutput("game_done", 32'(done), 32'd1);
      checkOutput("game_busy", 32'(busy), 32'd0);
      checkOutput("game_light", 32'(light), 32'd0);
    end else begin
      checkOutput("next_rnd_req", 32'(rnd_req), 32'd1);
    end
  endtask

  task automatic random_round();
    int sel;
    int hit_at;
    sel = $urandom_range(0, 7);
    if (sel == 0) hit_at = 0;
    else if (sel == 1) hit_at = WINDOW_CYCLES;
    else hit_at = $urandom_range(1, 40);
    applyStimulus(8'($urandom), $urandom_range(1, 4), hit_at, 1'($urandom), 1'b0);
  endtask

  initial begin
    #2;
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_rnd_req", 32'(rnd_req), 32'd0);
    checkOutput("reset_seed", 32'(seed), 32'd0);
    checkOutput("reset_light", 32'(light), 32'd0);
    checkOutput("reset_hm_enable", 32'(hm_enable), 32'd0);
    checkOutput("reset_score", 32'(score), 32'd0);
    checkOutput("reset_round_cnt", 32'(round_cnt), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("idle_busy", 32'(busy), 32'd0);
    checkOutput("idle_rnd_req", 32'(rnd_req), 32'd0);

    // Game 1: directed rounds first (A5 target, zero target with hit on timeout, miss with stray start)
    start_game();
    applyStimulus(8'hA5, 2, 10, 1'b0, 1'b0);
    applyStimulus(8'h00, 1, WINDOW_CYCLES, 1'b0, 1'b0);
    applyStimulus(8'($urandom), 3, 0, 1'b1, 1'b0);
    for (int r = 3; r < ROUNDS; r++) random_round();

    // Game 2: restart from DONE, every round a hit
    start_game();
    for (int r = 0; r < ROUNDS; r++)
      applyStimulus(8'($urandom), $urandom_range(1, 4), $urandom_range(1, 30), 1'b0, 1'b0);
`ifdef GAME_STREAK_EN
    checkOutput("all_hit_score", 32'(score), 32'd10);
`else
    checkOutput("all_hit_score", 32'(score), 32'd8);
`endif

    // Game 3: reset during SHOW of the third round
    start_game();
    random_round();
    random_round();
    applyStimulus(8'($urandom), 2, 5, 1'b0, 1'b1);
    repeat (5) @(negedge clk);
    checkOutput("post_reset_busy", 32'(busy), 32'd0);
    checkOutput("post_reset_rnd_req", 32'(rnd_req), 32'd0);
    checkOutput("post_reset_done", 32'(done), 32'd0);

    // Game 4: fully random
    start_game();
    for (int r = 0; r < ROUNDS; r++) random_round();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
